// File: rtl/fp_sqrt_ctrl_if.sv
// Handshake and core-side signal bundle for the square-root controller.
// The master modport belongs to the controller; the slave modport belongs to the operand source, the result sink and the core.
interface fp_sqrt_ctrl_if #(
  parameter int E_DW = 8,
  parameter int F_DW = 7
);
  localparam int W  = 1 + E_DW + F_DW;
  localparam int SW = F_DW + 1;
  localparam int RW = 2 * SW;

  logic          op_valid_i;
  logic          op_ready_o;
  logic [W-1:0]  op_i;
  logic          inv_i;
  logic          doSqrt_o;
  logic [SW-1:0] s_o;
  logic          is_exp_odd_o;
  logic          invSqrt_o;
  logic          special_case_o;
  logic          core_valid_i;
  logic [RW-1:0] core_res_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [W-1:0]  res_o;
  logic          timeout_o;

  modport master (
    input  op_valid_i, op_i, inv_i, core_valid_i, core_res_i, res_ready_i,
    output op_ready_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o, special_case_o,
           res_valid_o, res_o, timeout_o
  );

  modport slave (
    output op_valid_i, op_i, inv_i, core_valid_i, core_res_i, res_ready_i,
    input  op_ready_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o, special_case_o,
           res_valid_o, res_o, timeout_o
  );
endinterface

// File: rtl/fp_sqrt_ctrl.sv
// Unpack/classify, core sequencing and normalise/round/pack around the iterative sqrt core.
// state  | meaning
// IDLE   | ready for an operand; specials resolve here and jump straight to OUT
// ISSUE  | one-cycle start pulse to the core
// WAIT   | waiting for the core result or the timeout
// PACK   | normalise, round (RNE) and pack the captured core result
// OUT    | result presented until the consumer takes it
module fp_sqrt_ctrl #(
  parameter int E_DW        = 8,
  parameter int F_DW        = 7,
  parameter int BIAS        = 127,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst,
  fp_sqrt_ctrl_if.master bus
);
  localparam int W   = 1 + E_DW + F_DW;
  localparam int SW  = F_DW + 1;
  localparam int RW  = 2 * SW;
  localparam int EW  = E_DW + 2;
  localparam int LZW = $clog2(RW + 1);
  localparam int CW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [W-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
  localparam logic [W-1:0] INF  = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};
  localparam logic signed [EW-1:0] BIAS_S  = EW'(BIAS);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2**E_DW) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_PACK, S_OUT} state_t;
  state_t state, state_nxt;

  logic                 op_sign;
  logic [E_DW-1:0]      op_exp;
  logic [F_DW-1:0]      op_frac;
  logic                 is_zero, is_nan, is_inf, is_special;
  logic [W-1:0]         special_res;
  logic signed [EW-1:0] e_unb, e_half, rexp_in;

  logic [SW-1:0]        s_r;
  logic                 odd_r, inv_r, timeout_r;
  logic signed [EW-1:0] rexp_r;
  logic [RW-1:0]        cap_r;
  logic [W-1:0]         res_r;
  logic [CW-1:0]        wait_cnt;
  logic                 wait_done;

  logic [LZW-1:0]       lz;
  logic [RW-1:0]        m;
  logic [F_DW-1:0]      keep;
  logic                 guard, sticky, round_up;
  logic [F_DW:0]        sum;
  logic signed [EW-1:0] rexp_p;
  logic [W-1:0]         pack_res;

  function automatic logic [LZW-1:0] clz(input logic [RW-1:0] v);
    logic done;
    clz  = '0;
    done = 1'b0;
    for (int i = RW - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      clz  = clz + 1'b1;
      end
    end
  endfunction

  assign op_sign    = bus.op_i[W-1];
  assign op_exp     = bus.op_i[W-2 -: E_DW];
  assign op_frac    = bus.op_i[F_DW-1:0];
  assign is_zero    = (op_exp == '0);
  assign is_nan     = (&op_exp) && (|op_frac);
  assign is_inf     = (&op_exp) && !(|op_frac);
  assign is_special = is_zero || (&op_exp) || op_sign;

  assign e_unb   = $signed({2'b00, op_exp}) - BIAS_S;
  assign e_half  = e_unb >>> 1;
  assign rexp_in = bus.inv_i ? (BIAS_S - e_half) : (BIAS_S + e_half);

  always_comb begin
    special_res = '0;
    if (is_nan || (op_sign && !is_zero)) special_res = QNAN;
    else if (is_inf)                     special_res = bus.inv_i ? '0 : INF;
    else if (bus.inv_i)                  special_res = {op_sign, INF[W-2:0]};
    else                                 special_res = {op_sign, {(W-1){1'b0}}};
  end

  assign lz       = clz(cap_r);
  assign m        = cap_r << lz;
  assign keep     = m[RW-2 -: F_DW];
  assign guard    = m[RW-2-F_DW];
  assign sticky   = |m[RW-3-F_DW:0];
  assign round_up = guard & (sticky | keep[0]);
  assign sum      = {1'b0, keep} + {{F_DW{1'b0}}, round_up};
  assign rexp_p   = rexp_r - $signed({{(EW-LZW){1'b0}}, lz})
                           + $signed({{(EW-1){1'b0}}, sum[F_DW]});

  // On mantissa carry-out the low bits of sum are already zero, so they serve as the fraction directly.
  always_comb begin
    pack_res = '0;
    if (!m[RW-1] || rexp_p[EW-1] || (rexp_p == '0)) pack_res = '0;
    else if (rexp_p >= EXP_MAX)                     pack_res = INF;
    else                                            pack_res = {1'b0, rexp_p[E_DW-1:0], sum[F_DW-1:0]};
  end

  assign wait_done = (wait_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.op_valid_i) state_nxt = is_special ? S_OUT : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (bus.core_valid_i) state_nxt = S_PACK;
               else if (wait_done)   state_nxt = S_OUT;
      S_PACK:  state_nxt = S_OUT;
      S_OUT:   if (bus.res_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_r       <= '0;
      odd_r     <= 1'b0;
      inv_r     <= 1'b0;
      rexp_r    <= '0;
      cap_r     <= '0;
      res_r     <= '0;
      timeout_r <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.op_valid_i) begin
          inv_r     <= bus.inv_i;
          timeout_r <= 1'b0;
          wait_cnt  <= '0;
          if (is_special) begin
            res_r <= special_res;
          end else begin
            s_r    <= {1'b1, op_frac};
            odd_r  <= e_unb[0];
            rexp_r <= rexp_in;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (bus.core_valid_i) begin
            cap_r <= bus.core_res_i;
          end else if (wait_done) begin
            res_r     <= QNAN;
            timeout_r <= 1'b1;
          end
        end
        S_PACK:  res_r <= pack_res;
        S_OUT:   if (bus.res_ready_i) timeout_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.op_ready_o     = (state == S_IDLE);
  assign bus.doSqrt_o       = (state == S_ISSUE);
  assign bus.s_o            = s_r;
  assign bus.is_exp_odd_o   = odd_r;
  assign bus.invSqrt_o      = inv_r;
  assign bus.special_case_o = 1'b0;
  assign bus.res_valid_o    = (state == S_OUT);
  assign bus.res_o          = res_r;
  assign bus.timeout_o      = timeout_r;
endmodule

// File: tb/tb_fp_sqrt_ctrl.sv
// Directed bench for fp_sqrt_ctrl: arithmetic reference model, queue-based output checker, literal pins.
module tb_fp_sqrt_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [16:0] exp_q[$];   // {timeout, result}
  logic [9:0]  core_q[$];  // {is_exp_odd, inv, significand}

  fp_sqrt_ctrl_if #(.E_DW(8), .F_DW(7)) bus ();

  fp_sqrt_ctrl #(.E_DW(8), .F_DW(7), .BIAS(127), .TIMEOUT_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic bit is_special(input logic [15:0] op);
    return (op[14:7] == 8'h00) || (op[14:7] == 8'hFF) || op[15];
  endfunction

  function automatic logic [15:0] model_special(input logic [15:0] op, input bit inv);
    if (op[14:7] == 8'hFF && op[6:0] != 7'h0) return 16'h7FC0;
    if (op[15] && op[14:7] != 8'h00)          return 16'h7FC0;
    if (op[14:7] == 8'hFF)                    return inv ? 16'h0000 : 16'h7F80;
    if (inv)                                  return {op[15], 15'h7F80};
    return {op[15], 15'h0000};
  endfunction

  function automatic bit model_odd(input logic [15:0] op);
    int e = int'(op[14:7]) - 127;
    return (e % 2) != 0;
  endfunction

  // Value-level reference: result = core/2^15 * 2^(rexp-127), renormalised and rounded to 8 significant bits.
  function automatic logic [15:0] model_norm(input logic [15:0] op, input bit inv, input logic [15:0] core);
    int e, h, x, mv, q, r;
    e = int'(op[14:7]) - 127;
    h = (e >= 0) ? e / 2 : (e - 1) / 2;
    x = inv ? 127 - h : 127 + h;
    mv = int'(core);
    if (mv == 0) return 16'h0000;
    while (mv < 32768) begin
      mv = mv * 2;
      x  = x - 1;
    end
    q = mv / 256;
    r = mv % 256;
    if (r > 128 || (r == 128 && (q % 2) == 1)) q = q + 1;
    if (q == 256) begin
      q = 128;
      x = x + 1;
    end
    if (x <= 0)   return 16'h0000;
    if (x >= 255) return 16'h7F80;
    return {1'b0, x[7:0], q[6:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.res_valid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL res_spurious: got %h want no result", bus.res_o);
        end else begin
          chk("res_model", {15'd0, bus.timeout_o, bus.res_o}, {15'd0, exp_q[0]});
        end
      end
      if (bus.doSqrt_o) begin
        if (core_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL core_spurious: got doSqrt=1 want 0");
        end else begin
          chk("core_inputs", {22'd0, bus.is_exp_odd_o, bus.invSqrt_o, bus.s_o}, {22'd0, core_q[0]});
          chk("special_case_o", {31'd0, bus.special_case_o}, 32'd0);
          void'(core_q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.res_valid_o && bus.res_ready_i && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  task automatic take_result();
    #1 bus.res_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.res_ready_i = 1'b0;
    @(negedge clk);
    chk("released_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("released_ready", {31'd0, bus.op_ready_o}, 32'd1);
    chk("released_timeout", {31'd0, bus.timeout_o}, 32'd0);
  endtask

  task automatic run_op(input logic [15:0] op, input bit inv, input logic [15:0] core,
                        input int lat, input int hold, input logic [15:0] lit);
    bit          sp = is_special(op);
    logic [15:0] mexp;
    mexp = sp ? model_special(op, inv) : model_norm(op, inv, core);
    chk("model_pin", {16'd0, mexp}, {16'd0, lit});
    @(negedge clk);
    chk("ready_idle", {31'd0, bus.op_ready_o}, 32'd1);
    bus.op_valid_i = 1'b1;
    bus.op_i       = op;
    bus.inv_i      = inv;
    exp_q.push_back({1'b0, mexp});
    if (!sp) core_q.push_back({model_odd(op), inv, 1'b1, op[6:0]});
    @(posedge clk);
    #1 bus.op_valid_i = 1'b0;
    if (sp) begin
      @(negedge clk);
      chk("special_latency", {31'd0, bus.res_valid_o}, 32'd1);
    end else begin
      @(negedge clk);
      chk("issue_pulse", {31'd0, bus.doSqrt_o}, 32'd1);
      @(posedge clk);
      repeat (lat - 1) @(posedge clk);
      #1 bus.core_valid_i = 1'b1;
      bus.core_res_i = core;
      @(posedge clk);
      #1 bus.core_valid_i = 1'b0;
      bus.core_res_i = 16'h0000;
      @(negedge clk);
      chk("pack_cycle_valid", {31'd0, bus.res_valid_o}, 32'd0);
      @(negedge clk);
      chk("normal_latency", {31'd0, bus.res_valid_o}, 32'd1);
    end
    chk("res_literal", {16'd0, bus.res_o}, {16'd0, lit});
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.res_valid_o}, 32'd1);
      chk("hold_ready", {31'd0, bus.op_ready_o}, 32'd0);
      chk("hold_res", {16'd0, bus.res_o}, {16'd0, lit});
    end
    take_result();
  endtask

  task automatic run_timeout();
    @(negedge clk);
    bus.op_valid_i = 1'b1;
    bus.op_i       = 16'h4080;
    bus.inv_i      = 1'b0;
    exp_q.push_back({1'b1, 16'h7FC0});
    core_q.push_back({1'b0, 1'b0, 8'h80});
    @(posedge clk);
    #1 bus.op_valid_i = 1'b0;
    @(posedge clk);
    repeat (63) @(posedge clk);
    @(negedge clk);
    chk("timeout_early", {31'd0, bus.res_valid_o}, 32'd0);
    @(negedge clk);
    chk("timeout_valid", {31'd0, bus.res_valid_o}, 32'd1);
    chk("timeout_flag", {31'd0, bus.timeout_o}, 32'd1);
    chk("timeout_res", {16'd0, bus.res_o}, 32'h7FC0);
    take_result();
  endtask

  task automatic run_reset_in_wait();
    @(negedge clk);
    bus.op_valid_i = 1'b1;
    bus.op_i       = 16'h4000;
    bus.inv_i      = 1'b1;
    core_q.push_back({1'b1, 1'b1, 8'h80});
    @(posedge clk);
    #1 bus.op_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.op_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("rst_dosqrt", {31'd0, bus.doSqrt_o}, 32'd0);
    chk("rst_core_outs", {22'd0, bus.is_exp_odd_o, bus.invSqrt_o, bus.s_o}, 32'd0);
    chk("rst_res", {15'd0, bus.timeout_o, bus.res_o}, 32'd0);
    exp_q.delete();
    core_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1 bus.core_valid_i = 1'b1;
    bus.core_res_i = 16'h8000;
    @(posedge clk);
    #1 bus.core_valid_i = 1'b0;
    bus.core_res_i = 16'h0000;
    @(negedge clk);
    chk("late_core_valid", {31'd0, bus.res_valid_o}, 32'd0);
    chk("late_core_ready", {31'd0, bus.op_ready_o}, 32'd1);
  endtask

  initial begin
    bus.op_valid_i   = 1'b0;
    bus.op_i         = 16'h0000;
    bus.inv_i        = 1'b0;
    bus.core_valid_i = 1'b0;
    bus.core_res_i   = 16'h0000;
    bus.res_ready_i  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'd0, bus.op_ready_o}, 32'd1);
    chk("reset_outs", {15'd0, bus.res_valid_o, bus.doSqrt_o, bus.is_exp_odd_o, bus.invSqrt_o,
                       bus.special_case_o, bus.timeout_o, bus.s_o}, 32'd0);
    chk("reset_res", {16'd0, bus.res_o}, 32'd0);
    rst = 1'b0;

    run_op(16'h4080, 1'b0, 16'h8000, 3, 0,  16'h4000);
    run_op(16'h4000, 1'b0, 16'hB505, 1, 10, 16'h3FB5);
    run_op(16'h4080, 1'b1, 16'h8000, 5, 0,  16'h3F00);
    run_op(16'h3F80, 1'b0, 16'hFFFF, 2, 0,  16'h4000);
    run_op(16'h3F80, 1'b0, 16'h8180, 1, 0,  16'h3F82);
    run_op(16'h3F80, 1'b0, 16'h8080, 1, 0,  16'h3F80);
    run_op(16'h4000, 1'b1, 16'h5A82, 4, 0,  16'h3F35);
    run_op(16'h3E80, 1'b0, 16'h8000, 2, 0,  16'h3F00);
    run_op(16'h3F00, 1'b1, 16'hB505, 2, 0,  16'h4035);
    run_op(16'h3F80, 1'b0, 16'h0000, 1, 0,  16'h0000);

    run_op(16'hBF80, 1'b0, 16'h0000, 0, 0,  16'h7FC0);
    run_op(16'h0000, 1'b1, 16'h0000, 0, 0,  16'h7F80);
    run_op(16'h8000, 1'b0, 16'h0000, 0, 3,  16'h8000);
    run_op(16'h7F80, 1'b0, 16'h0000, 0, 0,  16'h7F80);
    run_op(16'h7F80, 1'b1, 16'h0000, 0, 0,  16'h0000);
    run_op(16'h7FC1, 1'b0, 16'h0000, 0, 0,  16'h7FC0);
    run_op(16'h8000, 1'b1, 16'h0000, 0, 0,  16'hFF80);
    run_op(16'h0001, 1'b0, 16'h0000, 0, 0,  16'h0000);
    run_op(16'hFF80, 1'b1, 16'h0000, 0, 0,  16'h7FC0);

    run_timeout();
    run_reset_in_wait();
    run_op(16'h4080, 1'b0, 16'h8000, 2, 0, 16'h4000);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
endmodule
